axi_burst_addr_gen: RTL

AXI_BURST_ADDR_GEN -- requirements
Module: axi_burst_addr_gen

---
 rtl/axi_burst_addr_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/axi_burst_addr_gen.sv
// AXI burst address generator: turns one AW/AR command into a stream of per-beat
// byte addresses and byte-lane strobes for FIXED, INCR and WRAP bursts.
module axi_burst_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [2:0]              cmd_size,
    input  logic [1:0]              cmd_burst,
    output logic                    beat_valid,
    input  logic                    beat_ready,
    output logic [ADDR_WIDTH-1:0]   beat_addr,
    output logic [DATA_WIDTH/8-1:0] beat_strb,
    output logic                    beat_last,
    output logic                    cmd_err
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned MAX_SIZE   = $clog2(STRB_WIDTH);
    localparam int unsigned LANE_W     = MAX_SIZE + 1;

    typedef enum logic {IDLE, BURST} state_t;
    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_enum_t;

    state_t                state, state_next;
    burst_enum_t           burst_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_next, wrap_mask_q;
    logic [ADDR_WIDTH-1:0] size_bytes, size_mask, aligned_addr;
    logic [ADDR_WIDTH-1:0] cmd_size_mask, cmd_wrap_mask;
    logic [7:0]            len_q, cnt_q;
    logic [2:0]            size_q;
    logic                  err_q;
    logic                  cmd_fire, beat_fire, cmd_illegal, last_beat;
    logic [LANE_W-1:0]     lo_lane, hi_lane;
    logic [STRB_WIDTH-1:0] strb_lanes;

    assign cmd_ready  = !rst && (state == IDLE);
    assign beat_valid = !rst && (state == BURST);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign beat_fire  = beat_valid && beat_ready;
    assign last_beat  = (cnt_q == len_q);

    assign beat_addr  = rst ? '0 : addr_q;
    assign beat_strb  = beat_valid ? strb_lanes : '0;
    assign beat_last  = beat_valid && last_beat;
    assign cmd_err    = !rst && err_q;

    // WRAP spans (len+1) * 2^size bytes; len+1 is a power of two, so a mask suffices
    assign cmd_size_mask = (ADDR_WIDTH'(1) << cmd_size) - ADDR_WIDTH'(1);
    assign cmd_wrap_mask = ((ADDR_WIDTH'(cmd_len) + ADDR_WIDTH'(1)) << cmd_size) - ADDR_WIDTH'(1);

    always_comb begin
        cmd_illegal = 1'b0;
        if (cmd_burst == BURST_RSVD)
            cmd_illegal = 1'b1;
        if (32'(cmd_size) > MAX_SIZE)
            cmd_illegal = 1'b1;
        if (cmd_burst == BURST_WRAP) begin
            if (!(cmd_len == 8'd1 || cmd_len == 8'd3 || cmd_len == 8'd7 || cmd_len == 8'd15))
                cmd_illegal = 1'b1;
            if ((cmd_addr & cmd_size_mask) != '0)
                cmd_illegal = 1'b1;
        end
    end

    assign size_bytes   = ADDR_WIDTH'(1) << size_q;
    assign size_mask    = size_bytes - ADDR_WIDTH'(1);
    assign aligned_addr = addr_q & ~size_mask;

    always_comb begin
        addr_next = addr_q;
        case (burst_q)
            BURST_INCR: addr_next = aligned_addr + size_bytes;
            BURST_WRAP: addr_next = (addr_q & ~wrap_mask_q) | ((addr_q + size_bytes) & wrap_mask_q);
            default:    addr_next = addr_q;
        endcase
    end

    // Lanes run from the unaligned start byte up to the end of the aligned beat
    always_comb begin
        lo_lane    = {1'b0, addr_q[MAX_SIZE-1:0]};
        hi_lane    = {1'b0, aligned_addr[MAX_SIZE-1:0]} + size_bytes[LANE_W-1:0] - LANE_W'(1);
        strb_lanes = '0;
        for (int unsigned i = 0; i < STRB_WIDTH; i++)
            strb_lanes[i] = (LANE_W'(i) >= lo_lane) && (LANE_W'(i) <= hi_lane);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_fire && !cmd_illegal) state_next = BURST;
            BURST:   if (beat_fire && last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            wrap_mask_q <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            size_q      <= '0;
            burst_q     <= BURST_FIXED;
            err_q       <= 1'b0;
        end else begin
            err_q <= cmd_fire && cmd_illegal;
            if (cmd_fire && !cmd_illegal) begin
                addr_q      <= cmd_addr;
                wrap_mask_q <= cmd_wrap_mask;
                len_q       <= cmd_len;
                cnt_q       <= '0;
                size_q      <= cmd_size;
                burst_q     <= burst_enum_t'(cmd_burst);
            end else if (beat_fire) begin
                addr_q <= addr_next;
                cnt_q  <= cnt_q + 8'd1;
            end
        end
    end
endmodule
